// File: rtl/timer_capture.sv
`default_nettype none
// ============================================================================
// timer_capture : counts clk cycles between selected edges of sig_in and
//                 reports each interval through a valid/ack handshake.
// Revision      : 1.0
// ============================================================================
module timer_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             arm,
  input  logic             continuous,
  input  logic [1:0]       edge_sel,
  input  logic             sig_in,
  input  logic             cap_ack,
  output logic [WIDTH-1:0] capture,
  output logic             cap_valid,
  output logic             saturated,
  output logic             overrun,
  output logic             busy
);

  localparam logic [1:0]       c_ST_IDLE    = 2'd0;
  localparam logic [1:0]       c_ST_ARMED   = 2'd1;
  localparam logic [1:0]       c_ST_MEASURE = 2'd2;
  localparam logic [WIDTH-1:0] c_CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_CNT_ONE    = WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [1:0]             r_state;
  logic [WIDTH-1:0]       r_count;
  logic                   r_cont;
  logic [1:0]             r_edge_sel;
  logic [WIDTH-1:0]       r_capture;
  logic                   r_cap_valid;
  logic                   r_saturated;
  logic                   r_overrun;

  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_cap_evt;

  // Synchroniser plus history flop; runs regardless of FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_fall    = ~r_sync[SYNC_STAGES-1] & r_hist;
  assign w_edge    = r_edge_sel[1] ? (w_rise | w_fall) : (r_edge_sel[0] ? w_fall : w_rise);
  assign w_cap_evt = enable && (r_state == c_ST_MEASURE) && w_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_count    <= '0;
      r_cont     <= 1'b0;
      r_edge_sel <= 2'b00;
    end else if (!enable) begin
      r_state <= c_ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (arm) begin
            r_state    <= c_ST_ARMED;
            r_cont     <= continuous;
            r_edge_sel <= edge_sel;
          end
        end
        c_ST_ARMED: begin
          if (w_edge) begin
            r_state <= c_ST_MEASURE;
            r_count <= c_CNT_ONE;
          end
        end
        c_ST_MEASURE: begin
          // The closing edge of one interval opens the next in continuous mode.
          if (w_edge) begin
            if (r_cont) begin
              r_count <= c_CNT_ONE;
            end else begin
              r_state <= c_ST_IDLE;
              r_count <= '0;
            end
          end else if (r_count != c_CNT_MAX) begin
            r_count <= r_count + c_CNT_ONE;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // New data wins over a coincident ack; otherwise unread data is kept and the loss flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_capture   <= '0;
      r_cap_valid <= 1'b0;
      r_saturated <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_cap_evt) begin
      if (!r_cap_valid || cap_ack) begin
        r_capture   <= r_count;
        r_saturated <= (r_count == c_CNT_MAX);
        r_cap_valid <= 1'b1;
        if (cap_ack) begin
          r_overrun <= 1'b0;
        end
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (cap_ack) begin
      r_cap_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign capture   = r_capture;
  assign cap_valid = r_cap_valid;
  assign saturated = r_saturated;
  assign overrun   = r_overrun;
  assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_timer_capture.sv
`default_nettype none
// ============================================================================
// tb_timer_capture : directed/randomized bench for timer_capture (WIDTH=8).
// Revision         : 1.0
// ============================================================================
module tb_timer_capture;

  localparam int WIDTH = 8;
  localparam int MAXV  = 255;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             arm;
  logic             continuous;
  logic [1:0]       edge_sel;
  logic             sig_in;
  logic             cap_ack;
  logic [WIDTH-1:0] capture;
  logic             cap_valid;
  logic             saturated;
  logic             overrun;
  logic             busy;

  int checks = 0;
  int errors = 0;

  timer_capture #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .arm        (arm),
    .continuous (continuous),
    .edge_sel   (edge_sel),
    .sig_in     (sig_in),
    .cap_ack    (cap_ack),
    .capture    (capture),
    .cap_valid  (cap_valid),
    .saturated  (saturated),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: an interval of d cycles between selected edges reads back as d, clamped at full scale.
  function automatic int sat_val(input int d);
    return (d > MAXV) ? MAXV : d;
  endfunction

  function automatic logic [31:0] sat_flag(input int d);
    return (d >= MAXV) ? 32'd1 : 32'd0;
  endfunction

  task automatic wave(input logic v, input int n);
    sig_in = v;
    repeat (n) tick();
  endtask

  task automatic quiet();
    sig_in = 1'b0;
    repeat (6) tick();
  endtask

  task automatic do_arm(input logic cont, input logic [1:0] sel);
    continuous = cont;
    edge_sel   = sel;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    continuous = 1'($urandom);
    edge_sel   = 2'($urandom);
  endtask

  task automatic do_ack();
    cap_ack = 1'b1;
    tick();
    cap_ack = 1'b0;
  endtask

  // Single-shot rising measurement of an interval of d cycles.
  task automatic single_rise(input int d);
    quiet();
    do_arm(1'b0, 2'b00);
    chk("single_busy_armed", 32'(busy), 32'd1);
    wave(1'b1, d / 2);
    wave(1'b0, d - d / 2);
    sig_in = 1'b1;
    repeat (2) tick();
    chk("single_not_early", 32'(cap_valid), 32'd0);
    tick();
    chk("single_capture", 32'(capture), 32'(sat_val(d)));
    chk("single_valid", 32'(cap_valid), 32'd1);
    chk("single_sat", 32'(saturated), sat_flag(d));
    chk("single_busy_done", 32'(busy), 32'd0);
    do_ack();
    chk("single_ack_clears", 32'(cap_valid), 32'd0);
  endtask

  // One level segment of a both-edge continuous run; checks the interval closed by its leading edge.
  task automatic seg(input logic v, input int len, input int prev, input bit check);
    sig_in = v;
    repeat (3) tick();
    if (check) begin
      chk("cont_capture", 32'(capture), 32'(sat_val(prev)));
      chk("cont_valid", 32'(cap_valid), 32'd1);
      chk("cont_sat", 32'(saturated), sat_flag(prev));
      chk("cont_overrun", 32'(overrun), 32'd0);
    end
    chk("cont_busy", 32'(busy), 32'd1);
    do_ack();
    repeat (len - 4) tick();
  endtask

  initial begin
    int prev;
    int len;
    int p1, p2, p3;
    int d;

    rst_n = 1'b0; enable = 1'b0; arm = 1'b0; continuous = 1'b0;
    edge_sel = 2'b00; sig_in = 1'b0; cap_ack = 1'b0;
    repeat (3) tick();
    chk("rst_capture", 32'(capture), 32'd0);
    chk("rst_valid", 32'(cap_valid), 32'd0);
    chk("rst_sat", 32'(saturated), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Single-shot rising, including the saturation boundary.
    single_rise(100);
    single_rise(int'($urandom_range(10, 200)));
    single_rise(254);
    single_rise(255);
    single_rise(300);
    single_rise(int'($urandom_range(256, 500)));

    // Continuous both-edge square wave, then random segment lengths.
    quiet();
    do_arm(1'b1, {1'b1, 1'($urandom)});
    seg(1'b1, 30, 0, 1'b0);
    seg(1'b0, 70, 30, 1'b1);
    seg(1'b1, 30, 70, 1'b1);
    seg(1'b0, 70, 30, 1'b1);
    prev = 70;
    for (int i = 0; i < 6; i++) begin
      len = int'($urandom_range(5, 300));
      seg(!sig_in, len, prev, 1'b1);
      prev = len;
    end

    // Reset in the middle of a measurement with unread data.
    sig_in = !sig_in;
    repeat (3) tick();
    chk("prerst_valid", 32'(cap_valid), 32'd1);
    chk("prerst_capture", 32'(capture), 32'(sat_val(prev)));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(cap_valid), 32'd0);
    chk("midrst_capture", 32'(capture), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);

    // Overrun: three rising-edge intervals, no ack until the third capture.
    quiet();
    p1 = int'($urandom_range(20, 60));
    p2 = p1 + int'($urandom_range(1, 20));
    p3 = p2 + int'($urandom_range(1, 20));
    do_arm(1'b1, 2'b00);
    wave(1'b1, p1 / 2);
    wave(1'b0, p1 - p1 / 2);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("ovr_first_capture", 32'(capture), 32'(p1));
    chk("ovr_first_flag", 32'(overrun), 32'd0);
    repeat (p2 / 2 - 3) tick();
    wave(1'b0, p2 - p2 / 2);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("ovr_held_capture", 32'(capture), 32'(p1));
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_still_valid", 32'(cap_valid), 32'd1);
    repeat (p3 / 2 - 3) tick();
    wave(1'b0, p3 - p3 / 2);
    sig_in = 1'b1;
    repeat (2) tick();
    do_ack();
    chk("ovr_ack_capture", 32'(capture), 32'(p3));
    chk("ovr_ack_valid", 32'(cap_valid), 32'd1);
    chk("ovr_ack_clear", 32'(overrun), 32'd0);

    // Abort while measuring; captured data survives, later edges are ignored.
    repeat (5) tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_keep_valid", 32'(cap_valid), 32'd1);
    do_ack();
    chk("abort_ack_valid", 32'(cap_valid), 32'd0);
    wave(1'b0, 5);
    wave(1'b1, 5);
    wave(1'b0, 5);
    chk("abort_no_capture", 32'(cap_valid), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    // Arm without enable is ignored.
    enable = 1'b0;
    arm    = 1'b1;
    tick();
    arm    = 1'b0;
    enable = 1'b1;
    tick();
    chk("arm_no_enable", 32'(busy), 32'd0);

    // A second arm while busy must not replace the latched configuration.
    quiet();
    d = int'($urandom_range(20, 120));
    do_arm(1'b0, 2'b00);
    do_arm(1'b1, 2'b01);
    chk("rearm_busy", 32'(busy), 32'd1);
    wave(1'b1, d / 2);
    wave(1'b0, d - d / 2);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("rearm_capture", 32'(capture), 32'(d));
    chk("rearm_single", 32'(busy), 32'd0);
    do_ack();

    // One-cycle pulse in both-edge mode: edge on the first measuring cycle.
    quiet();
    do_arm(1'b0, 2'b10);
    wave(1'b1, 1);
    wave(1'b0, 3);
    chk("pulse_capture", 32'(capture), 32'd1);
    chk("pulse_valid", 32'(cap_valid), 32'd1);
    chk("pulse_sat", 32'(saturated), 32'd0);
    chk("pulse_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
